// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data memory: load formats, store sizes and the
// byte-offset masks used to detect misaligned halfword/word accesses.
package riscv_mem_pkg;

    // Load format codes carried on readdatasel.
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_fmt_e;

    // Store size codes carried on writedatasel; 2'b11 is a silent no-op.
    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_size_e;

    // Offset bits that must be zero for each access size.
    localparam logic [1:0] BYTE_ALIGN_MASK = 2'b00;
    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // True when the byte offset violates the given alignment mask.
    function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] mask);
        return |(offset & mask);
    endfunction

endpackage

// File: rtl/memory_if.sv
// Memory request/response bundle between a load/store unit and data_memory.
interface memory_if #(
    parameter int DW = 32,
    parameter int AW = 9
);
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    readdatasel;
    logic [1:0]    writedatasel;
    logic [1:0]    writeEnable;
    logic [DW-1:0] rdata;

    modport master (
        output wr, addr, wdata, readdatasel, writedatasel, writeEnable,
        input  rdata
    );

    modport slave (
        input  wr, addr, wdata, readdatasel, writedatasel, writeEnable,
        output rdata
    );
endinterface

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it to DW bits.
module load_extend
    import riscv_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] word,
    input  logic [1:0]    offset,
    input  logic [2:0]    format,
    output logic [DW-1:0] result
);

    logic [DW-1:0] w_shifted;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // Halfword loads are only ever aligned, so a byte-granular shift serves both sizes.
    assign w_shifted = word >> {offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    // Format select; unknown codes deliberately return zero.
    always_comb begin
        result = '0;
        case (format)
            LD_LB:   result = {{(DW-8){w_byte[7]}}, w_byte};
            LD_LH:   result = {{(DW-16){w_half[15]}}, w_half};
            LD_LW:   result = word;
            LD_LBU:  result = {{(DW-8){1'b0}}, w_byte};
            LD_LHU:  result = {{(DW-16){1'b0}}, w_half};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with byte-lane stores, a two-stage load path
// (synchronous array read, then registered extension) and misalign flagging.
//
// Request protocol: each cycle is one request, sampled at the rising edge.
//   store : wr=1 and writeEnable[0]=1 (writeEnable[1] is ignored when wr=1)
//   load  : wr=0 and writeEnable[1]=1
//   idle  : anything else (writeEnable 2'b00 is the canonical idle)
// There is no backpressure. A load sampled at edge N drives rdata from edge
// N+1 onward, and rdata holds until the next accepted load. A misaligned
// request is dropped and misalign is high for the single cycle after it.
module data_memory
    import riscv_mem_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic     clk,
    input  logic     rst,
    memory_if.slave  mem,
    output logic     misalign
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** (AW - 2);
    localparam logic [NB-1:0] BE_BYTE = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [NB-1:0] BE_HALF = {{(NB-2){1'b0}}, 2'b11};

    logic [DW-1:0] r_mem [DEPTH];

    logic [AW-3:0] w_idx;
    logic [1:0]    w_off;
    logic          w_st_req;
    logic          w_ld_req;
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_lanes;
    logic          w_st_mis;
    logic          w_ld_mis;
    logic          w_st_commit;
    logic          w_ld_take;
    logic [DW-1:0] w_ext;

    logic          r_ld_valid;
    logic [DW-1:0] r_word;
    logic [1:0]    r_ld_off;
    logic [2:0]    r_ld_fmt;
    logic [DW-1:0] r_rdata;
    logic          r_misalign;

    // The word index naturally wraps modulo DEPTH since it is just the upper address bits.
    assign w_idx    = mem.addr[AW-1:2];
    assign w_off    = mem.addr[1:0];
    assign w_st_req = mem.wr & mem.writeEnable[0] & ~rst;
    assign w_ld_req = mem.writeEnable[1] & ~mem.wr & ~rst;

    // Store decode: lane enables, replicated write data and alignment check.
    always_comb begin
        w_be     = '0;
        w_lanes  = '0;
        w_st_mis = 1'b0;
        case (mem.writedatasel)
            ST_SB: begin
                w_be     = BE_BYTE << w_off;
                w_lanes  = {NB{mem.wdata[7:0]}};
                w_st_mis = is_misaligned(w_off, BYTE_ALIGN_MASK);
            end
            ST_SH: begin
                w_be     = BE_HALF << {w_off[1], 1'b0};
                w_lanes  = {(NB/2){mem.wdata[15:0]}};
                w_st_mis = is_misaligned(w_off, HALF_ALIGN_MASK);
            end
            ST_SW: begin
                w_be     = '1;
                w_lanes  = mem.wdata;
                w_st_mis = is_misaligned(w_off, WORD_ALIGN_MASK);
            end
            default: begin
                w_be     = '0;
                w_lanes  = '0;
                w_st_mis = 1'b0;
            end
        endcase
    end

    // Load alignment check; unknown formats are treated as aligned and return zero.
    always_comb begin
        w_ld_mis = 1'b0;
        case (mem.readdatasel)
            LD_LH, LD_LHU: w_ld_mis = is_misaligned(w_off, HALF_ALIGN_MASK);
            LD_LW:         w_ld_mis = is_misaligned(w_off, WORD_ALIGN_MASK);
            default:       w_ld_mis = 1'b0;
        endcase
    end

    assign w_st_commit = w_st_req & ~w_st_mis;
    assign w_ld_take   = w_ld_req & ~w_ld_mis;

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_st_commit && w_be[i]) begin
                r_mem[w_idx][i*8 +: 8] <= w_lanes[i*8 +: 8];
            end
        end
    end

    // Synchronous array read captured with the load's offset and format.
    always_ff @(posedge clk) begin
        if (w_ld_take) begin
            r_word   <= r_mem[w_idx];
            r_ld_off <= w_off;
            r_ld_fmt <= mem.readdatasel;
        end
    end

    // Load-in-flight flag; reset kills a load that was sampled just before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_valid <= 1'b0;
        end else begin
            r_ld_valid <= w_ld_take;
        end
    end

    load_extend #(.DW(DW)) u_load_extend (
        .word   (r_word),
        .offset (r_ld_off),
        .format (r_ld_fmt),
        .result (w_ext)
    );

    // Response register: updated only by a completing load, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (r_ld_valid) begin
            r_rdata <= w_ext;
        end
    end

    // One-cycle misalign pulse for any dropped store or load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (w_st_req & w_st_mis) | (w_ld_req & w_ld_mis);
        end
    end

    assign mem.rdata = r_rdata;
    assign misalign  = r_misalign;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 9, byte-address width; the array holds 2**AW bytes as 2**(AW-2) words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem  memory_if.slave  --  responder end of the memory interface (wr, addr, wdata, readdatasel, writedatasel, writeEnable in; rdata out).
REQ-006 misalign  output  1  one-cycle pulse flagging a rejected misaligned access.

Function
REQ-007 addr SHALL be a byte address: addr[AW-1:2] is the word index, addr[1:0] the byte offset.
REQ-008 writeEnable[0] SHALL gate writes; writeEnable[1] SHALL mark a load request; writeEnable 2'b00 means idle.
REQ-009 A store SHALL commit at the clock edge when wr=1, writeEnable[0]=1, rst=0 and the access is aligned.
REQ-010 writedatasel SHALL select the store size: 00 SB (lane addr[1:0] <- wdata[7:0]), 01 SH (lanes addr[1]*2..+1 <- wdata[15:0]), 10 SW (all lanes <- wdata); 11 SHALL be ignored and raise no error.
REQ-011 Unselected byte lanes SHALL keep their value.
REQ-012 A load SHALL be sampled when writeEnable[1]=1 and wr=0; rdata SHALL update exactly one cycle after the sampling edge.
REQ-013 readdatasel SHALL select the load format: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; any other code SHALL return 0.
REQ-014 rdata SHALL hold its last value in every cycle without a new load.
REQ-015 Alignment rule: halfword accesses require addr[0]=0; word accesses require addr[1:0]=00.
REQ-016 A misaligned store SHALL leave memory unchanged.
REQ-017 A misaligned load SHALL leave rdata unchanged.
REQ-018 misalign SHALL pulse high one cycle after any misaligned store or load.
REQ-019 wr=1 together with writeEnable[1]=1 SHALL be treated as a store only; no load occurs.
REQ-020 A load in the cycle directly after a store to the same word SHALL return the newly written data (no stale read).
REQ-021 Address wrap: the word index SHALL be taken modulo 2**(AW-2); no out-of-range error exists.

Reset
REQ-022 While rst=1, rdata SHALL be 0 and misalign SHALL be 0.
REQ-023 While rst=1, stores and loads SHALL be suppressed, including an access in the same cycle reset asserts.
REQ-024 A load sampled before reset asserts SHALL NOT deliver data after reset.
REQ-025 Array contents SHALL NOT be cleared by reset.

Structure
REQ-026 A shared package (riscv_mem_pkg) SHALL hold the load-format enum (LB/LH/LW/LBU/LHU), the store-size enum (SB/SH/SW) and the alignment helper constants.
REQ-027 Sign/zero extension SHALL be a combinational sub-module load_extend (inputs: word, offset, format; output: DW-bit result).
REQ-028 The array SHALL be a byte-lane-writable register array, inferable as block RAM with byte enables.

Verification
REQ-029 SW 0xDEADBEEF to addr 0x010, then LW 0x010 -> rdata=0xDEADBEEF one cycle after the load; misalign=0.
REQ-030 After REQ-029: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
REQ-031 SB 0x55 to addr 0x011 over 0xDEADBEEF, then LW 0x010 -> 0xDEAD55EF.
REQ-032 SW to 0x022, then LW 0x020 -> prior contents unchanged; misalign pulses one cycle each after the SW and after an LH at 0x021.
REQ-033 Store and load issued in the same cycle, then LW on the next cycle to the same word -> new data returned; store with writeEnable[0]=0 -> memory unchanged.
REQ-034 rst asserted in the cycle after an LW is sampled -> rdata=0 and stays 0; after deassert, LW returns the data stored before reset.
